ftrace_sched: RTL and testbench

- Collects function-trace events (jal/jalr commits) from several requesters, e.g. the commit slots and the trap-return path.
- Arbitrates the requesters round-robin and buffers events in a small FIFO.
- Drains one event per handshake to a single function-trace sink, which makes the DPI call.
- Classifies each event as call or return and tracks the call depth reported alongside it.

---
 rtl/ftrace_pkg.sv | 36 +++
 rtl/ftrace_fifo.sv | 58 +++++
 rtl/ftrace_sched.sv | 121 ++++++++++++
 tb/tb_ftrace_sched.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ftrace_pkg.sv
// Shared types and constants for the function-trace event scheduler.
package ftrace_pkg;

  // Head-event classification codes reported on out_kind.
  localparam logic [1:0] FT_KIND_OTHER = 2'd0;
  localparam logic [1:0] FT_KIND_CALL  = 2'd1;
  localparam logic [1:0] FT_KIND_RET   = 2'd2;

  // Link registers: ra and the alternate link register t0.
  localparam logic [4:0] RA = 5'd1;
  localparam logic [4:0] T0 = 5'd5;

  // Reference width for the event layout; the scheduler rescales pc/nextpc/inst to its XLEN.
  localparam int FT_XLEN = 32;

  typedef struct packed {
    logic [FT_XLEN-1:0] pc;
    logic [FT_XLEN-1:0] nextpc;
    logic [FT_XLEN-1:0] inst;
    logic               is_jal;
    logic [5:0]         rd;
  } ft_event_t;

  // A write to a link register is a call; a jalr through a link register discarding the result is a return.
  function automatic logic [1:0] ft_classify(input logic is_jal, input logic [4:0] rd5,
                                             input logic [4:0] rs1);
    logic rd_link;
    logic rs1_link;
    rd_link  = (rd5 == RA) || (rd5 == T0);
    rs1_link = (rs1 == RA) || (rs1 == T0);
    if (rd_link) return FT_KIND_CALL;
    else if (!is_jal && (rd5 == 5'd0) && rs1_link) return FT_KIND_RET;
    else return FT_KIND_OTHER;
  endfunction

endpackage

// File: rtl/ftrace_fifo.sv
// Synchronous FIFO with flush; the caller guarantees no push when full and no pop when empty.
module ftrace_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Pointer and occupancy next-state; flush returns everything to the empty position.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop) cnt_d = cnt_q + CW'(1);
      else if (pop && !push) cnt_d = cnt_q - CW'(1);
    end
  end

  // State registers and storage; storage is cleared on reset so the head reads zero.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push && !flush) mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = cnt_q;

endmodule

// File: rtl/ftrace_sched.sv
// Round-robin collector of function-trace events feeding a single sink through a FIFO,
// with call/return classification and call-depth tracking of the head event.
//
// Handshakes: a requester's event is taken on any cycle its req_valid and req_ready are
// both high (req_ready is a grant and depends on req_valid); the sink takes the head on
// any cycle out_valid and out_ready are both high. out_valid never depends on out_ready,
// and the head stays stable until it is taken. Nothing is taken while flush is high.
module ftrace_sched
  import ftrace_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*XLEN-1:0] req_pc,
  input  logic [NREQ*XLEN-1:0] req_nextpc,
  input  logic [NREQ*XLEN-1:0] req_inst,
  input  logic [NREQ-1:0]    req_is_jal,
  input  logic [NREQ*6-1:0]  req_rd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [XLEN-1:0]    out_nextpc,
  output logic [XLEN-1:0]    out_inst,
  output logic               out_is_jal,
  output logic [5:0]         out_rd,
  output logic [1:0]         out_kind,
  output logic [7:0]         out_depth,
  output logic [15:0]        stall_cnt
);
  // Event layout follows ft_event_t with the three wide fields rescaled to XLEN.
  localparam int EW  = $bits(ft_event_t) - 3 * FT_XLEN + 3 * XLEN;
  localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW  = $clog2(DEPTH) + 1;

  logic [CW-1:0]   count;
  logic [EW-1:0]   push_ev, head_ev;
  logic [RRW-1:0]  rr_q, rr_d, gnt_idx, cand;
  logic            found, eligible, push, pop;
  logic [7:0]      depth_q, depth_d;
  logic [15:0]     stall_q, stall_d;

  // Round-robin grant: first valid requester at or after rr_q, only when there is room.
  always_comb begin
    gnt_idx   = '0;
    cand      = '0;
    found     = 1'b0;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = RRW'((int'(rr_q) + i) % NREQ);
      if (!found && req_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    eligible = reset && !flush && (count < CW'(DEPTH));
    push     = eligible && found;
    if (push) req_ready[gnt_idx] = 1'b1;
  end

  assign push_ev = {req_pc[int'(gnt_idx)*XLEN +: XLEN],
                    req_nextpc[int'(gnt_idx)*XLEN +: XLEN],
                    req_inst[int'(gnt_idx)*XLEN +: XLEN],
                    req_is_jal[gnt_idx],
                    req_rd[int'(gnt_idx)*6 +: 6]};

  ftrace_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (push_ev),
    .dout  (head_ev),
    .count (count)
  );

  assign {out_pc, out_nextpc, out_inst, out_is_jal, out_rd} = head_ev;
  assign out_valid = reset && (count != '0);
  assign pop       = out_valid && out_ready && !flush;
  assign out_kind  = ft_classify(out_is_jal, out_rd[4:0], out_inst[19:15]);
  assign out_depth = depth_q;
  assign stall_cnt = stall_q;

  // Next-state for rr pointer, call depth and stall counter.
  always_comb begin
    rr_d    = rr_q;
    depth_d = depth_q;
    stall_d = stall_q;
    if (push) begin
      if (int'(gnt_idx) == NREQ - 1) rr_d = '0;
      else rr_d = gnt_idx + RRW'(1);
    end
    if (flush) begin
      depth_d = '0;
    end else if (pop) begin
      if (out_kind == FT_KIND_CALL && depth_q != 8'hFF) depth_d = depth_q + 8'd1;
      else if (out_kind == FT_KIND_RET && depth_q != 8'h00) depth_d = depth_q - 8'd1;
    end
    if (!flush && (|req_valid) && !push && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_q    <= '0;
      depth_q <= '0;
      stall_q <= '0;
    end else begin
      rr_q    <= rr_d;
      depth_q <= depth_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_ftrace_sched.sv
// Directed bench for ftrace_sched: reset, round-robin order, classification/depth table,
// full FIFO back-pressure, flush and mid-stream reset.
module tb_ftrace_sched;
  localparam int NREQ = 2;
  localparam int XLEN = 32;

  logic              clock, reset, flush;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*XLEN-1:0] req_pc, req_nextpc, req_inst;
  logic [NREQ-1:0]   req_is_jal;
  logic [NREQ*6-1:0] req_rd;
  logic              out_valid, out_ready, out_is_jal;
  logic [XLEN-1:0]   out_pc, out_nextpc, out_inst;
  logic [5:0]        out_rd;
  logic [1:0]        out_kind;
  logic [7:0]        out_depth;
  logic [15:0]       stall_cnt;

  int errors = 0;
  int checks = 0;
  logic [XLEN-1:0] exp_q[$];

  typedef struct {
    logic       is_jal;
    logic [5:0] rd;
    logic [4:0] rs1;
    logic [1:0] kind;
    logic [7:0] depth;
  } vec_t;
  vec_t tbl[11];

  ftrace_sched #(.NREQ(NREQ), .DEPTH(8), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_pc(req_pc), .req_nextpc(req_nextpc), .req_inst(req_inst),
    .req_is_jal(req_is_jal), .req_rd(req_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_nextpc(out_nextpc), .out_inst(out_inst),
    .out_is_jal(out_is_jal), .out_rd(out_rd), .out_kind(out_kind),
    .out_depth(out_depth), .stall_cnt(stall_cnt)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_slot(input int s, input logic [31:0] pc, input logic [31:0] inst,
                          input logic is_jal, input logic [5:0] rd);
    req_pc[s*XLEN +: XLEN]     = pc;
    req_nextpc[s*XLEN +: XLEN] = pc + 32'h40;
    req_inst[s*XLEN +: XLEN]   = inst;
    req_is_jal[s]              = is_jal;
    req_rd[s*6 +: 6]           = rd;
  endtask

  function automatic logic [31:0] mk_inst(input logic [4:0] rs1);
    return (32'(rs1) << 15) | 32'h67;
  endfunction

  initial begin
    logic [31:0] pc0, pc1;
    logic [1:0]  exp_g;

    tbl[0]  = '{1'b1, 6'd1,  5'd0, 2'd1, 8'd0};
    tbl[1]  = '{1'b1, 6'd5,  5'd0, 2'd1, 8'd1};
    tbl[2]  = '{1'b0, 6'd0,  5'd1, 2'd2, 8'd2};
    tbl[3]  = '{1'b0, 6'd0,  5'd5, 2'd2, 8'd1};
    tbl[4]  = '{1'b0, 6'd0,  5'd1, 2'd2, 8'd0};
    tbl[5]  = '{1'b1, 6'd0,  5'd1, 2'd0, 8'd0};
    tbl[6]  = '{1'b0, 6'd2,  5'd1, 2'd0, 8'd0};
    tbl[7]  = '{1'b0, 6'd1,  5'd1, 2'd1, 8'd0};
    tbl[8]  = '{1'b0, 6'd33, 5'd2, 2'd1, 8'd1};
    tbl[9]  = '{1'b0, 6'd0,  5'd3, 2'd0, 8'd2};
    tbl[10] = '{1'b0, 6'd0,  5'd5, 2'd2, 8'd2};

    reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
    req_valid = '0; req_pc = '0; req_nextpc = '0; req_inst = '0; req_is_jal = '0; req_rd = '0;

    // Reset: requests during reset get no grant; everything reads zero.
    req_valid = 2'b11;
    step(); step();
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    chk("rst_depth", 64'(out_depth), 64'd0);
    chk("rst_pc",    64'(out_pc),    64'd0);
    reset = 1'b1; req_valid = '0;
    step();

    // Round robin: both requesters valid, sink always ready.
    pc0 = 32'h100; pc1 = 32'h200;
    set_slot(0, pc0, 32'h6F, 1'b1, 6'd0);
    set_slot(1, pc1, 32'h6F, 1'b1, 6'd0);
    req_valid = 2'b11; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      chk("rr_grant", 64'(req_ready), 64'(exp_g));
      if (exp_g[0]) exp_q.push_back(pc0); else exp_q.push_back(pc1);
      chk("rr_valid", 64'(out_valid), (k == 0) ? 64'd0 : 64'd1);
      if (k > 0) chk("rr_order", 64'(out_pc), 64'(exp_q.pop_front()));
      step();
      if (exp_g[0]) begin pc0 += 4; set_slot(0, pc0, 32'h6F, 1'b1, 6'd0); end
      else begin pc1 += 4; set_slot(1, pc1, 32'h6F, 1'b1, 6'd0); end
    end
    req_valid = '0;
    for (int n = 0; n < 8 && exp_q.size() > 0; n++) begin
      #1;
      chk("rr_drain_valid", 64'(out_valid), 64'd1);
      chk("rr_drain_pc", 64'(out_pc), 64'(exp_q.pop_front()));
      step();
    end
    #1;
    chk("rr_empty", 64'(out_valid), 64'd0);
    chk("rr_left", 64'(exp_q.size()), 64'd0);
    out_ready = 1'b0;

    // Classification and call depth, one event at a time through requester 0.
    for (int t = 0; t < 11; t++) begin
      pc0 = 32'h3000 + 32'(t) * 32'h10;
      set_slot(0, pc0, mk_inst(tbl[t].rs1), tbl[t].is_jal, tbl[t].rd);
      req_valid = 2'b01;
      #1;
      chk("tbl_grant", 64'(req_ready), 64'd1);
      step();
      req_valid = '0;
      #1;
      chk("tbl_valid",  64'(out_valid),  64'd1);
      chk("tbl_kind",   64'(out_kind),   64'(tbl[t].kind));
      chk("tbl_depth",  64'(out_depth),  64'(tbl[t].depth));
      chk("tbl_pc",     64'(out_pc),     64'(pc0));
      chk("tbl_nextpc", 64'(out_nextpc), 64'(pc0 + 32'h40));
      chk("tbl_inst",   64'(out_inst),   64'(mk_inst(tbl[t].rs1)));
      chk("tbl_is_jal", 64'(out_is_jal), 64'(tbl[t].is_jal));
      chk("tbl_rd",     64'(out_rd),     64'(tbl[t].rd));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    #1;
    chk("tbl_final_depth", 64'(out_depth), 64'd1);

    // Full FIFO: 9 offers with the sink stalled, then a pop that must not free a slot early.
    for (int k = 0; k < 9; k++) begin
      pc0 = 32'h5000 + 32'(k) * 32'h4;
      set_slot(0, pc0, 32'h6F, 1'b1, 6'd0);
      req_valid = 2'b01;
      #1;
      chk("full_grant", 64'(req_ready), (k < 8) ? 64'd1 : 64'd0);
      if (k < 8) exp_q.push_back(pc0);
      step();
    end
    chk("full_stall1", 64'(stall_cnt), 64'd1);
    out_ready = 1'b1;
    #1;
    chk("no_bypass", 64'(req_ready), 64'd0);
    chk("full_depth", 64'(out_depth), 64'd1);
    chk("full_head", 64'(out_pc), 64'(exp_q.pop_front()));
    step();
    out_ready = 1'b0;
    #1;
    chk("after_pop_grant", 64'(req_ready), 64'd1);
    chk("full_stall2", 64'(stall_cnt), 64'd2);
    exp_q.push_back(pc0);
    step();
    req_valid = '0; out_ready = 1'b1;
    for (int n = 0; n < 12 && exp_q.size() > 0; n++) begin
      #1;
      chk("full_drain_valid", 64'(out_valid), 64'd1);
      chk("full_drain_pc", 64'(out_pc), 64'(exp_q.pop_front()));
      step();
    end
    out_ready = 1'b0;
    #1;
    chk("full_left", 64'(exp_q.size()), 64'd0);
    chk("full_empty", 64'(out_valid), 64'd0);

    // Flush with 3 buffered events and a pending request.
    for (int k = 0; k < 3; k++) begin
      set_slot(0, 32'h6000 + 32'(k) * 32'h4, 32'h6F, 1'b1, 6'd0);
      req_valid = 2'b01;
      step();
    end
    #1;
    chk("pre_flush_valid", 64'(out_valid), 64'd1);
    chk("pre_flush_depth", 64'(out_depth), 64'd1);
    flush = 1'b1; out_ready = 1'b1; req_valid = 2'b01;
    #1;
    chk("flush_ready", 64'(req_ready), 64'd0);
    step();
    flush = 1'b0; out_ready = 1'b0; req_valid = '0;
    #1;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_depth", 64'(out_depth), 64'd0);
    chk("flush_stall", 64'(stall_cnt), 64'd2);

    // Reset mid-stream with 4 calls queued and depth at 1.
    for (int k = 0; k < 5; k++) begin
      set_slot(0, 32'h6800 + 32'(k) * 32'h4, 32'h6F, 1'b1, 6'd1);
      req_valid = 2'b01;
      step();
    end
    req_valid = '0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #1;
    chk("pre_rst_depth", 64'(out_depth), 64'd1);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    reset = 1'b0; req_valid = 2'b01;
    #1;
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    step();
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    chk("post_rst_depth", 64'(out_depth), 64'd0);
    chk("post_rst_stall", 64'(stall_cnt), 64'd0);
    chk("post_rst_pc",    64'(out_pc),    64'd0);
    reset = 1'b1;
    set_slot(0, 32'h7000, 32'h6F, 1'b1, 6'd0);
    #1;
    chk("resume_grant", 64'(req_ready), 64'd1);
    step();
    req_valid = '0;
    #1;
    chk("resume_valid", 64'(out_valid), 64'd1);
    chk("resume_pc",    64'(out_pc),    64'h7000);
    chk("resume_kind",  64'(out_kind),  64'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #1;
    chk("resume_empty", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
